munoc_inter_router_fifo_sync: RTL and testbench
===============================================

Name: munoc_inter_router_fifo_sync

Overview:
- Single-clock, parametrised inter-router buffer for one MUNOC router-to-router hop.
- Buffers the forward channel (rfni→sfni) and the backward channel (sbni→rbni), each with its own independent depth.
- Depth 0 on a channel turns that channel into a plain wire.
- Adds per-channel occupancy, an almost-full flag and a clearable high-water mark for NoC congestion profiling.

Parameters:
BW_FNI_PHIT, 8, forward phit width; forward link width LWF = `BW_FNI_LINK(BW_FNI_PHIT)
BW_BNI_PHIT, 8, backward phit width; backward link width LWB = `BW_BNI_LINK(BW_BNI_PHIT)
DEPTH_FNI, 4, forward entries; legal range 0..64; need not be a power of 2
DEPTH_BNI, 4, backward entries; legal range 0..64
AFULL_FNI, DEPTH_FNI-1, forward almost-full threshold in entries
AFULL_BNI, DEPTH_BNI-1, backward almost-full threshold in entries
BW_CNT, 7, width of occupancy and watermark outputs; ceil(log2(64+1))

Ports:
clk  input  1  the block's only clock
rstnn  input  1  reset; synchronous, active-low
rfni_link  input  LWF  forward ingress; MSB = valid, [LWF-2:0] = phit
rfni_ready  output  1  forward ingress ready
sfni_link  output  LWF  forward egress; MSB = valid
sfni_ready  input  1  forward egress ready
sbni_link  input  LWB  backward ingress; MSB = valid
sbni_ready  output  1  backward ingress ready
rbni_link  output  LWB  backward egress; MSB = valid
rbni_ready  input  1  backward egress ready
stat_clear  input  1  clears both watermarks
fni_count  output  BW_CNT  forward occupancy
bni_count  output  BW_CNT  backward occupancy
fni_afull  output  1  fni_count >= AFULL_FNI
bni_afull  output  1  bni_count >= AFULL_BNI
fni_peak  output  BW_CNT  forward high-water mark
bni_peak  output  BW_CNT  backward high-water mark

Behaviour:
- Each channel is an identical, independent FIFO instance.
- Transfer definitions, evaluated on the rising clk edge:
  - push = ingress valid & ingress ready
  - pop = egress valid & egress ready
- Ingress ready = rstnn & (count < DEPTH). Ready never depends combinationally on egress ready.
- Egress valid = (count != 0). Egress phit = mem[rptr]. Phit is don't-care while valid = 0.
- Latency: a push into an empty FIFO is visible at egress on the next cycle. Throughput is 1 phit per cycle.
- Pointers wrap from DEPTH-1 to 0. Non-power-of-2 depths must wrap exactly at DEPTH-1.
- count update per cycle: +1 on push only, -1 on pop only, unchanged on push+pop or neither.
- Full: ready = 0, so ingress valid is ignored. A pop on the same cycle frees a slot, and ready rises on the next cycle.
- Empty: pop is impossible because valid = 0. Push+pop cannot occur on the same cycle.
- Ordering: strict FIFO, no reorder, no drop.
- Watermark:
  - peak <= max(peak, count_next) every cycle.
  - stat_clear = 1: peak <= count_next, which takes priority over the max update.
- afull is combinational from the count register.
- DEPTH = 0:
  - egress link = ingress link; ingress ready = egress ready.
  - count, afull and peak are tied to 0.
- Reset (rstnn = 0 at an edge):
  - Clears pointers, count and peak.
  - While rstnn = 0, all valids and readys are 0 and count/afull/peak read 0.
  - In-flight data is discarded; storage is not reset.
  - Reset asserted mid-burst: egress valid is 0 on the first cycle after the reset edge.

Decomposition:
- Shared package/header, munoc_link_fifo_pkg: link field-split helpers (valid = MSB, phit = low bits) and the BW_CNT computation macro.
- Sub-module munoc_link_fifo (params BW_DATA, DEPTH, AFULL, BW_CNT) implements one channel, including the DEPTH = 0 generate branch.
- The top level instantiates it twice and splits each link into valid and phit.

Test Plan:
1. DEPTH_FNI=4: push 0x11,0x22,0x33,0x44 with sfni_ready=0 → rfni_ready=0 after the 4th push; fni_count=4; fni_afull=1 from count 3; fni_peak=4. Then sfni_ready=1 → egress order 11,22,33,44, one per cycle, and rfni_ready=1 one cycle after the first pop.
2. Full FIFO, simultaneous offer of 0x55 with a pop → 0x55 is not accepted; fni_count=3 next cycle; 0x55 is accepted the cycle after that.
3. DEPTH_BNI=3 (non-power-of-2): stream 10 phits 0x00..0x09 with random rbni_ready → all 10 arrive in order; pointers wrap correctly; bni_count never exceeds 3.
4. Continuous push+pop at count=2 for 20 cycles → count stays 2; peak stays 2. Pulse stat_clear with count=2 → peak=2. Drain, then pulse stat_clear → peak=0.
5. Assert rstnn=0 for 1 cycle with count=3 mid-burst → next cycle count=0, sfni valid=0, peak=0. Ingress ready is 0 during reset and 1 after.
6. DEPTH_FNI=0: toggle sfni_ready → rfni_ready follows it in the same cycle; sfni_link equals rfni_link combinationally; fni_count/fni_peak/fni_afull read 0.

Source files
------------

// File: rtl/munoc_link_fifo_pkg.sv
// Shared helpers for MUNOC link FIFOs: link-width and counter-width math,
// plus the per-cycle transfer encoding used by the channel FIFO.
package munoc_link_fifo_pkg;

   localparam int MAX_DEPTH = 64;

   // A link is one valid bit (MSB) on top of the phit.
   function automatic int link_width(input int bw_phit);
      return bw_phit + 1;
   endfunction

   function automatic int cnt_width(input int max_depth);
      return $clog2(max_depth + 1);
   endfunction

   localparam int BW_CNT_DFLT = cnt_width(MAX_DEPTH);

   typedef enum logic [1:0] {
      XFER_IDLE = 2'b00,
      XFER_POP  = 2'b01,
      XFER_PUSH = 2'b10,
      XFER_BOTH = 2'b11
   } xfer_e;

endpackage

// File: rtl/munoc_link_fifo.sv
// One channel of the inter-router buffer: a valid/ready FIFO with occupancy,
// almost-full and high-water-mark outputs; DEPTH = 0 degenerates to a wire.
module munoc_link_fifo
   import munoc_link_fifo_pkg::*;
#(
   parameter int BW_DATA = 8,
   parameter int DEPTH   = 4,
   parameter int AFULL   = DEPTH - 1,
   parameter int BW_CNT  = BW_CNT_DFLT
) (
   input  logic               clk,
   input  logic               rstnn,
   input  logic               in_valid,
   input  logic [BW_DATA-1:0] in_data,
   output logic               in_ready,
   output logic               out_valid,
   output logic [BW_DATA-1:0] out_data,
   input  logic               out_ready,
   input  logic               stat_clear,
   output logic [BW_CNT-1:0]  count,
   output logic               afull,
   output logic [BW_CNT-1:0]  peak
);

   generate
      if (DEPTH == 0) begin : g_wire
         assign out_valid = in_valid;
         assign out_data  = in_data;
         assign in_ready  = out_ready;
         assign count     = '0;
         assign afull     = 1'b0;
         assign peak      = '0;
      end else begin : g_fifo
         localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
         localparam logic [PW-1:0]     LAST    = PW'(DEPTH - 1);
         localparam logic [BW_CNT-1:0] DEPTH_C = BW_CNT'(DEPTH);
         localparam logic [BW_CNT-1:0] AFULL_C = BW_CNT'(AFULL);

         logic [BW_DATA-1:0] mem [DEPTH];
         logic [PW-1:0]      rptr;
         logic [PW-1:0]      wptr;
         logic [BW_CNT-1:0]  cnt;
         logic [BW_CNT-1:0]  cnt_next;
         logic [BW_CNT-1:0]  peak_q;
         logic               push;
         logic               pop;
         xfer_e              xfer;

         // Ready comes only from the count register, never from out_ready.
         assign in_ready  = rstnn & (cnt < DEPTH_C);
         assign out_valid = rstnn & (cnt != '0);
         assign out_data  = mem[rptr];

         assign push = in_valid & in_ready;
         assign pop  = out_valid & out_ready;
         assign xfer = xfer_e'({push, pop});

         always_comb begin
            cnt_next = cnt;
            unique case (xfer)
               XFER_PUSH: cnt_next = cnt + 1'b1;
               XFER_POP:  cnt_next = cnt - 1'b1;
               default:   cnt_next = cnt;
            endcase
         end

         // Pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
         always_ff @(posedge clk) begin
            if (!rstnn) begin
               rptr   <= '0;
               wptr   <= '0;
               cnt    <= '0;
               peak_q <= '0;
            end else begin
               if (push) wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
               if (pop)  rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
               cnt <= cnt_next;
               if (stat_clear || (cnt_next > peak_q)) peak_q <= cnt_next;
            end
         end

         always_ff @(posedge clk) begin
            if (push) mem[wptr] <= in_data;
         end

         assign count = rstnn ? cnt : '0;
         assign afull = rstnn & (cnt >= AFULL_C);
         assign peak  = rstnn ? peak_q : '0;
      end
   endgenerate

endmodule

// File: rtl/munoc_inter_router_fifo_sync.sv
// Inter-router hop buffer: independent FIFOs for the forward (rfni->sfni)
// and backward (sbni->rbni) link channels, with congestion statistics.
module munoc_inter_router_fifo_sync
   import munoc_link_fifo_pkg::*;
#(
   parameter int BW_FNI_PHIT = 8,
   parameter int BW_BNI_PHIT = 8,
   parameter int DEPTH_FNI   = 4,
   parameter int DEPTH_BNI   = 4,
   parameter int AFULL_FNI   = DEPTH_FNI - 1,
   parameter int AFULL_BNI   = DEPTH_BNI - 1,
   parameter int BW_CNT      = 7,
   localparam int LWF = link_width(BW_FNI_PHIT),
   localparam int LWB = link_width(BW_BNI_PHIT)
) (
   input  logic              clk,
   input  logic              rstnn,
   input  logic [LWF-1:0]    rfni_link,
   output logic              rfni_ready,
   output logic [LWF-1:0]    sfni_link,
   input  logic              sfni_ready,
   input  logic [LWB-1:0]    sbni_link,
   output logic              sbni_ready,
   output logic [LWB-1:0]    rbni_link,
   input  logic              rbni_ready,
   input  logic              stat_clear,
   output logic [BW_CNT-1:0] fni_count,
   output logic [BW_CNT-1:0] bni_count,
   output logic              fni_afull,
   output logic              bni_afull,
   output logic [BW_CNT-1:0] fni_peak,
   output logic [BW_CNT-1:0] bni_peak
);

   logic                   sfni_valid;
   logic [BW_FNI_PHIT-1:0] sfni_phit;
   logic                   rbni_valid;
   logic [BW_BNI_PHIT-1:0] rbni_phit;

   munoc_link_fifo #(
      .BW_DATA (BW_FNI_PHIT),
      .DEPTH   (DEPTH_FNI),
      .AFULL   (AFULL_FNI),
      .BW_CNT  (BW_CNT)
   ) u_fni (
      .clk        (clk),
      .rstnn      (rstnn),
      .in_valid   (rfni_link[LWF-1]),
      .in_data    (rfni_link[LWF-2:0]),
      .in_ready   (rfni_ready),
      .out_valid  (sfni_valid),
      .out_data   (sfni_phit),
      .out_ready  (sfni_ready),
      .stat_clear (stat_clear),
      .count      (fni_count),
      .afull      (fni_afull),
      .peak       (fni_peak)
   );

   munoc_link_fifo #(
      .BW_DATA (BW_BNI_PHIT),
      .DEPTH   (DEPTH_BNI),
      .AFULL   (AFULL_BNI),
      .BW_CNT  (BW_CNT)
   ) u_bni (
      .clk        (clk),
      .rstnn      (rstnn),
      .in_valid   (sbni_link[LWB-1]),
      .in_data    (sbni_link[LWB-2:0]),
      .in_ready   (sbni_ready),
      .out_valid  (rbni_valid),
      .out_data   (rbni_phit),
      .out_ready  (rbni_ready),
      .stat_clear (stat_clear),
      .count      (bni_count),
      .afull      (bni_afull),
      .peak       (bni_peak)
   );

   assign sfni_link = {sfni_valid, sfni_phit};
   assign rbni_link = {rbni_valid, rbni_phit};

endmodule

// File: tb/tb_munoc_inter_router_fifo_sync.sv
// Scoreboard bench: a queue-based reference model per channel checks the
// buffered instance (fwd depth 4, bwd depth 3) and a depth-0 wire instance.
module tb_munoc_inter_router_fifo_sync;

   logic       clk = 1'b0;
   logic       rstnn;
   logic       stat_clear;

   logic [8:0] rfni_link, sfni_link, sbni_link, rbni_link;
   logic       rfni_ready, sfni_ready, sbni_ready, rbni_ready;
   logic [6:0] fni_count, bni_count, fni_peak, bni_peak;
   logic       fni_afull, bni_afull;

   logic [8:0] w_rfni_link, w_sfni_link, w_sbni_link, w_rbni_link;
   logic       w_rfni_ready, w_sfni_ready, w_sbni_ready, w_rbni_ready;
   logic [6:0] w_fni_count, w_bni_count, w_fni_peak, w_bni_peak;
   logic       w_fni_afull, w_bni_afull;

   int tests = 0;
   int fails = 0;

   logic [7:0] mq [2][$];
   int         mpk [2];
   int         rx [2];
   int         DEPTHS [2] = '{4, 3};

   always #5 clk = ~clk;

   munoc_inter_router_fifo_sync #(.DEPTH_FNI(4), .DEPTH_BNI(3)) dut (
      .clk(clk), .rstnn(rstnn),
      .rfni_link(rfni_link), .rfni_ready(rfni_ready),
      .sfni_link(sfni_link), .sfni_ready(sfni_ready),
      .sbni_link(sbni_link), .sbni_ready(sbni_ready),
      .rbni_link(rbni_link), .rbni_ready(rbni_ready),
      .stat_clear(stat_clear),
      .fni_count(fni_count), .bni_count(bni_count),
      .fni_afull(fni_afull), .bni_afull(bni_afull),
      .fni_peak(fni_peak), .bni_peak(bni_peak)
   );

   munoc_inter_router_fifo_sync #(.DEPTH_FNI(0)) dut_wire (
      .clk(clk), .rstnn(rstnn),
      .rfni_link(w_rfni_link), .rfni_ready(w_rfni_ready),
      .sfni_link(w_sfni_link), .sfni_ready(w_sfni_ready),
      .sbni_link(w_sbni_link), .sbni_ready(w_sbni_ready),
      .rbni_link(w_rbni_link), .rbni_ready(w_rbni_ready),
      .stat_clear(stat_clear),
      .fni_count(w_fni_count), .bni_count(w_bni_count),
      .fni_afull(w_fni_afull), .bni_afull(w_bni_afull),
      .fni_peak(w_fni_peak), .bni_peak(w_bni_peak)
   );

   task automatic checkOutput(input string name, input int ch, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s ch%0d: got %0h expected %0h at %0t", name, ch, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic rst_n, input logic fv, input logic [7:0] fd, input logic fr,
                                input logic bv, input logic [7:0] bd, input logic br, input logic clr);
      @(posedge clk);
      #1;
      rstnn        = rst_n;
      rfni_link    = {fv, fd};
      sfni_ready   = fr;
      sbni_link    = {bv, bd};
      rbni_ready   = br;
      stat_clear   = clr;
      w_rfni_link  = 9'($urandom);
      w_sfni_ready = 1'($urandom);
      w_sbni_link  = 9'($urandom);
      w_rbni_ready = 1'($urandom);
   endtask

   // Reference model and scoreboard: evaluated mid-cycle, it predicts the
   // handshake of the coming edge from queue occupancy alone.
   always @(negedge clk) begin
      logic       in_v [2];
      logic [7:0] in_d [2];
      logic       o_r [2];
      logic       a_rdy [2];
      logic       a_v [2];
      logic [7:0] a_d [2];
      logic [6:0] a_cnt [2];
      logic       a_af [2];
      logic [6:0] a_pk [2];
      int         sz;
      logic       e_rdy, e_v;

      in_v[0] = rfni_link[8]; in_d[0] = rfni_link[7:0]; o_r[0] = sfni_ready;
      a_rdy[0] = rfni_ready; a_v[0] = sfni_link[8]; a_d[0] = sfni_link[7:0];
      a_cnt[0] = fni_count; a_af[0] = fni_afull; a_pk[0] = fni_peak;
      in_v[1] = sbni_link[8]; in_d[1] = sbni_link[7:0]; o_r[1] = rbni_ready;
      a_rdy[1] = sbni_ready; a_v[1] = rbni_link[8]; a_d[1] = rbni_link[7:0];
      a_cnt[1] = bni_count; a_af[1] = bni_afull; a_pk[1] = bni_peak;

      for (int ch = 0; ch < 2; ch++) begin
         sz    = mq[ch].size();
         e_rdy = rstnn && (sz < DEPTHS[ch]);
         e_v   = rstnn && (sz != 0);
         checkOutput("ready", ch, 32'(a_rdy[ch]), 32'(e_rdy));
         checkOutput("valid", ch, 32'(a_v[ch]), 32'(e_v));
         checkOutput("count", ch, 32'(a_cnt[ch]), rstnn ? 32'(sz) : 32'd0);
         checkOutput("afull", ch, 32'(a_af[ch]), 32'(rstnn && (sz >= DEPTHS[ch] - 1)));
         checkOutput("peak", ch, 32'(a_pk[ch]), rstnn ? 32'(mpk[ch]) : 32'd0);
         if (e_v && a_v[ch]) checkOutput("data", ch, 32'(a_d[ch]), 32'(mq[ch][0]));

         if (!rstnn) begin
            mq[ch].delete();
            mpk[ch] = 0;
         end else begin
            if (e_v && o_r[ch]) begin
               void'(mq[ch].pop_front());
               rx[ch]++;
            end
            if (in_v[ch] && e_rdy) mq[ch].push_back(in_d[ch]);
            if (stat_clear || (mq[ch].size() > mpk[ch])) mpk[ch] = mq[ch].size();
         end
      end

      checkOutput("wire link", 2, 32'(w_sfni_link), 32'(w_rfni_link));
      checkOutput("wire ready", 2, 32'(w_rfni_ready), 32'(w_sfni_ready));
      checkOutput("wire count", 2, 32'(w_fni_count), 32'd0);
      checkOutput("wire peak", 2, 32'(w_fni_peak), 32'd0);
      checkOutput("wire afull", 2, 32'(w_fni_afull), 32'd0);
   end

   initial begin
      logic [7:0] t1 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      int         idx;
      logic       bv, br;

      rstnn = 1'b0; stat_clear = 1'b0;
      rfni_link = '0; sfni_ready = 1'b0; sbni_link = '0; rbni_ready = 1'b0;
      w_rfni_link = '0; w_sfni_ready = 1'b0; w_sbni_link = '0; w_rbni_ready = 1'b0;
      rx[0] = 0; rx[1] = 0; mpk[0] = 0; mpk[1] = 0;

      repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

      // Fill to full, then offer 0x55 against a full FIFO while popping.
      for (int i = 0; i < 4; i++) applyStimulus(1, 1, t1[i], 0, 0, 0, 0, 0);
      repeat (2) applyStimulus(1, 1, 8'h55, 1, 0, 0, 0, 0);
      repeat (6) applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);

      // Watermark: clear at empty, steady push+pop at count 2, clear, drain, clear.
      applyStimulus(1, 0, 0, 1, 0, 0, 0, 1);
      repeat (2) applyStimulus(1, 1, 8'($urandom), 0, 0, 0, 0, 0);
      repeat (20) applyStimulus(1, 1, 8'($urandom), 1, 0, 0, 0, 0);
      applyStimulus(1, 1, 8'($urandom), 1, 0, 0, 0, 1);
      repeat (3) applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 1, 0, 0, 0, 1);

      // Reset mid-burst with three entries held.
      repeat (3) applyStimulus(1, 1, 8'($urandom), 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 8'hA5, 0, 0, 0, 0, 0);
      repeat (2) applyStimulus(1, 1, 8'($urandom), 0, 0, 0, 0, 0);
      repeat (4) applyStimulus(1, 0, 0, 1, 0, 0, 0, 0);

      // Backward depth-3 channel: stream 0x00..0x09 with random ready.
      idx = 0;
      for (int cyc = 0; cyc < 300 && idx < 10; cyc++) begin
         bv = ($urandom_range(0, 3) != 0);
         br = 1'($urandom);
         applyStimulus(1, 0, 0, 0, bv, 8'(idx), br, 0);
         @(negedge clk);
         if (bv && sbni_ready) idx++;
      end
      checkOutput("stream sent", 1, 32'(idx), 32'd10);
      repeat (5) applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
      @(negedge clk);
      checkOutput("stream rx", 1, 32'(rx[1]), 32'd10);

      // Mixed random traffic on both channels.
      for (int cyc = 0; cyc < 400; cyc++)
         applyStimulus(1, 1'($urandom), 8'($urandom), 1'($urandom),
                       1'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
      repeat (6) applyStimulus(1, 0, 0, 1, 0, 0, 1, 0);
      @(negedge clk);
      checkOutput("drained", 0, 32'(mq[0].size() + mq[1].size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
